// File: rtl/cdpga_uart_rx.sv
// 8N1 serial receiver: synchronizes and majority-filters rx, recovers bytes, flags framing errors.
// Optional bus-idle detector built when RX_IDLE_DETECT_EN is defined; otherwise idle_o is tied low.
module cdpga_uart_rx #(
   parameter int CLK_DIV   = 139,
   parameter int IDLE_BITS = 10
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       rx,
   output logic [7:0] data_o,
   output logic       data_vld_o,
   output logic       err_o,
   output logic       busy_o,
   output logic       idle_o
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_BREAK
   } state_t;

   localparam logic [15:0] SAMPLE_PT = 16'(CLK_DIV / 2);
   localparam logic [15:0] LAST_CNT  = 16'(CLK_DIV - 1);

   logic [1:0]  sync_q, sync_d;
   logic [2:0]  hist_q, hist_d;
   logic [1:0]  flush_q, flush_d;
   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [3:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  data_q, data_d;
   logic        vld_q, vld_d;
   logic        err_q, err_d;

   logic rx_s;
   logic filt;
   logic fall;
   logic samp;
   logic wrap;

   assign rx_s = sync_q[1];
   assign filt = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
   // Sync stages reset high, so an edge is only trusted once real pin data has flushed through.
   assign fall = (flush_q == 2'd3) & hist_q[0] & ~rx_s;
   assign samp = (cnt_q == SAMPLE_PT);
   assign wrap = (cnt_q == LAST_CNT);

   always_comb begin
      sync_d  = {sync_q[0], rx};
      hist_d  = {hist_q[1:0], rx_s};
      flush_d = (flush_q == 2'd3) ? flush_q : flush_q + 2'd1;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = wrap ? 16'd0 : cnt_q + 16'd1;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      vld_d   = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d = 16'd0;
            bit_d = 4'd0;
            if (fall) state_d = ST_START;
         end
         ST_START: begin
            if (samp && filt) begin
               state_d = ST_IDLE;
            end else if (wrap) begin
               state_d = ST_DATA;
               bit_d   = 4'd0;
            end
         end
         ST_DATA: begin
            if (samp) begin
               shift_d = {filt, shift_q[7:1]};
               bit_d   = bit_q + 4'd1;
            end
            if (wrap && bit_q == 4'd8) state_d = ST_STOP;
         end
         ST_STOP: begin
            // Leave at the sample point so a following start bit is not missed.
            if (samp) begin
               if (filt) begin
                  data_d  = shift_q;
                  vld_d   = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  err_d   = 1'b1;
                  state_d = ST_BREAK;
               end
            end
         end
         ST_BREAK: begin
            cnt_d = 16'd0;
            if (rx_s) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q  <= 2'b11;
         hist_q  <= 3'b111;
         flush_q <= 2'd0;
         state_q <= ST_IDLE;
         cnt_q   <= 16'd0;
         bit_q   <= 4'd0;
         shift_q <= 8'h00;
         data_q  <= 8'h00;
         vld_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         hist_q  <= hist_d;
         flush_q <= flush_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         vld_q   <= vld_d;
         err_q   <= err_d;
      end
   end

   assign data_o     = data_q;
   assign data_vld_o = vld_q;
   assign err_o      = err_q;
   assign busy_o     = (state_q != ST_IDLE);

`ifdef RX_IDLE_DETECT_EN
   localparam int IDLE_MAX = IDLE_BITS * CLK_DIV;
   localparam int IW       = $clog2(IDLE_MAX + 1);

   logic [IW-1:0] idle_cnt_q, idle_cnt_d;

   always_comb begin
      idle_cnt_d = idle_cnt_q;
      if (!rx_s)
         idle_cnt_d = '0;
      else if (idle_cnt_q != IW'(IDLE_MAX))
         idle_cnt_d = idle_cnt_q + 1'b1;
   end

   // Reset loads the saturated value so the bus reads idle straight out of reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) idle_cnt_q <= IW'(IDLE_MAX);
      else       idle_cnt_q <= idle_cnt_d;
   end

   assign idle_o = (idle_cnt_q == IW'(IDLE_MAX));
`else
   logic unused_idle_cfg;
   assign unused_idle_cfg = ^32'(IDLE_BITS);
   assign idle_o = 1'b0;
`endif

endmodule
